// File: rtl/game_flow_controller.sv
// Screen/stage sequencer: requests banners from the display datapath, holds finished
// banners for HOLD_CYCLES, and gates gameplay for stages 1..3 through win/lose/restart.
module game_flow_controller #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic       stage_clear,
    input  logic       player_dead,
    input  logic       SAVE_GPA_done,
    input  logic       stage_1_begin_done,
    input  logic       stage_1_end_display_done,
    input  logic       stage_2_begin_done,
    input  logic       stage_2_end_display_done,
    input  logic       stage_3_begin_done,
    input  logic       stage_3_end_display_done,
    input  logic       WIN_done,
    input  logic       LOSE_done,
    output logic       wait_start,
    output logic       stage_1_begin,
    output logic       stage_1_done,
    output logic       stage_2_begin,
    output logic       stage_2_done,
    output logic       stage_3_begin,
    output logic       stage_3_done,
    output logic       win,
    output logic       game_over,
    output logic       play_enable,
    output logic [1:0] stage_num,
    output logic       display_rst
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [4:0] {
        ST_START_DRAW = 5'd0,
        ST_START_WAIT = 5'd1,
        ST_S1_BEGIN   = 5'd2,
        ST_S1_BHOLD   = 5'd3,
        ST_S1_PLAY    = 5'd4,
        ST_S1_DONE    = 5'd5,
        ST_S1_DHOLD   = 5'd6,
        ST_S2_BEGIN   = 5'd7,
        ST_S2_BHOLD   = 5'd8,
        ST_S2_PLAY    = 5'd9,
        ST_S2_DONE    = 5'd10,
        ST_S2_DHOLD   = 5'd11,
        ST_S3_BEGIN   = 5'd12,
        ST_S3_BHOLD   = 5'd13,
        ST_S3_PLAY    = 5'd14,
        ST_S3_DONE    = 5'd15,
        ST_S3_DHOLD   = 5'd16,
        ST_WIN_DRAW   = 5'd17,
        ST_WIN_IDLE   = 5'd18,
        ST_LOSE_DRAW  = 5'd19,
        ST_LOSE_IDLE  = 5'd20,
        ST_RESTART    = 5'd21
    } state_t;

    // Output vector layout: {flags[8:0], play_enable, stage_num[1:0], display_rst}
    localparam logic [12:0] OUT_RESET = 13'h1000;

    state_t         state_r;
    state_t         state_nx_s;
    logic [CW-1:0]  hold_cnt_r;
    logic           hold_exp_s;
    logic [12:0]    out_nx_s;
    logic [12:0]    out_r;

    function automatic logic is_hold(input state_t s);
        case (s)
            ST_S1_BHOLD, ST_S1_DHOLD,
            ST_S2_BHOLD, ST_S2_DHOLD,
            ST_S3_BHOLD, ST_S3_DHOLD: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    assign hold_exp_s = (hold_cnt_r == {CW{1'b0}});

    // Next-state logic
    always_comb begin
        state_nx_s = ST_START_DRAW;
        case (state_r)
            ST_START_DRAW: state_nx_s = SAVE_GPA_done ? ST_START_WAIT : ST_START_DRAW;
            ST_START_WAIT: state_nx_s = start_key ? ST_S1_BEGIN : ST_START_WAIT;
            ST_S1_BEGIN:   state_nx_s = stage_1_begin_done ? ST_S1_BHOLD : ST_S1_BEGIN;
            ST_S1_BHOLD:   state_nx_s = hold_exp_s ? ST_S1_PLAY : ST_S1_BHOLD;
            ST_S1_PLAY:    state_nx_s = player_dead ? ST_LOSE_DRAW :
                                        (stage_clear ? ST_S1_DONE : ST_S1_PLAY);
            ST_S1_DONE:    state_nx_s = stage_1_end_display_done ? ST_S1_DHOLD : ST_S1_DONE;
            ST_S1_DHOLD:   state_nx_s = hold_exp_s ? ST_S2_BEGIN : ST_S1_DHOLD;
            ST_S2_BEGIN:   state_nx_s = stage_2_begin_done ? ST_S2_BHOLD : ST_S2_BEGIN;
            ST_S2_BHOLD:   state_nx_s = hold_exp_s ? ST_S2_PLAY : ST_S2_BHOLD;
            ST_S2_PLAY:    state_nx_s = player_dead ? ST_LOSE_DRAW :
                                        (stage_clear ? ST_S2_DONE : ST_S2_PLAY);
            ST_S2_DONE:    state_nx_s = stage_2_end_display_done ? ST_S2_DHOLD : ST_S2_DONE;
            ST_S2_DHOLD:   state_nx_s = hold_exp_s ? ST_S3_BEGIN : ST_S2_DHOLD;
            ST_S3_BEGIN:   state_nx_s = stage_3_begin_done ? ST_S3_BHOLD : ST_S3_BEGIN;
            ST_S3_BHOLD:   state_nx_s = hold_exp_s ? ST_S3_PLAY : ST_S3_BHOLD;
            ST_S3_PLAY:    state_nx_s = player_dead ? ST_LOSE_DRAW :
                                        (stage_clear ? ST_S3_DONE : ST_S3_PLAY);
            ST_S3_DONE:    state_nx_s = stage_3_end_display_done ? ST_S3_DHOLD : ST_S3_DONE;
            ST_S3_DHOLD:   state_nx_s = hold_exp_s ? ST_WIN_DRAW : ST_S3_DHOLD;
            ST_WIN_DRAW:   state_nx_s = WIN_done ? ST_WIN_IDLE : ST_WIN_DRAW;
            ST_WIN_IDLE:   state_nx_s = start_key ? ST_RESTART : ST_WIN_IDLE;
            ST_LOSE_DRAW:  state_nx_s = LOSE_done ? ST_LOSE_IDLE : ST_LOSE_DRAW;
            ST_LOSE_IDLE:  state_nx_s = start_key ? ST_RESTART : ST_LOSE_IDLE;
            ST_RESTART:    state_nx_s = ST_START_DRAW;
            default:       state_nx_s = ST_START_DRAW;
        endcase
    end

    // Output decode of the upcoming state so registered outputs line up with state_r
    always_comb begin
        out_nx_s = 13'h0000;
        case (state_nx_s)
            ST_START_DRAW: out_nx_s = 13'h1000;
            ST_S1_BEGIN:   out_nx_s = {9'h080, 1'b0, 2'd1, 1'b0};
            ST_S1_BHOLD:   out_nx_s = {9'h000, 1'b0, 2'd1, 1'b0};
            ST_S1_PLAY:    out_nx_s = {9'h000, 1'b1, 2'd1, 1'b0};
            ST_S1_DONE:    out_nx_s = {9'h040, 1'b0, 2'd1, 1'b0};
            ST_S2_BEGIN:   out_nx_s = {9'h020, 1'b0, 2'd2, 1'b0};
            ST_S2_BHOLD:   out_nx_s = {9'h000, 1'b0, 2'd2, 1'b0};
            ST_S2_PLAY:    out_nx_s = {9'h000, 1'b1, 2'd2, 1'b0};
            ST_S2_DONE:    out_nx_s = {9'h010, 1'b0, 2'd2, 1'b0};
            ST_S3_BEGIN:   out_nx_s = {9'h008, 1'b0, 2'd3, 1'b0};
            ST_S3_BHOLD:   out_nx_s = {9'h000, 1'b0, 2'd3, 1'b0};
            ST_S3_PLAY:    out_nx_s = {9'h000, 1'b1, 2'd3, 1'b0};
            ST_S3_DONE:    out_nx_s = {9'h004, 1'b0, 2'd3, 1'b0};
            ST_WIN_DRAW:   out_nx_s = {9'h002, 1'b0, 2'd0, 1'b0};
            ST_LOSE_DRAW:  out_nx_s = {9'h001, 1'b0, 2'd0, 1'b0};
            ST_RESTART:    out_nx_s = {9'h000, 1'b0, 2'd0, 1'b1};
            default:       out_nx_s = 13'h0000;
        endcase
    end

    // State and registered output bank
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r <= ST_START_DRAW;
            out_r   <= OUT_RESET;
        end else begin
            state_r <= state_nx_s;
            out_r   <= out_nx_s;
        end
    end

    // Hold timer: loaded on entry to a hold state, counts down without wrapping
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if ((state_nx_s != state_r) && is_hold(state_nx_s)) begin
            hold_cnt_r <= HOLD_LOAD;
        end else if (is_hold(state_r) && !hold_exp_s) begin
            hold_cnt_r <= hold_cnt_r - CW'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign {wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done,
            stage_3_begin, stage_3_done, win, game_over} = out_r[12:4];
    assign play_enable = out_r[3];
    assign stage_num   = out_r[2:1];
    assign display_rst = out_r[0];

endmodule

// File: tb/tb_game_flow_controller.sv
// Table-driven bench for game_flow_controller with HOLD_CYCLES=4; expected outputs are
// queued as each cycle's stimulus is driven and popped when the cycle's result is sampled.
module tb_game_flow_controller;

    localparam int unsigned HOLD = 4;

    // Flag positions in {wait_start .. game_over}
    localparam logic [8:0] N   = 9'h000;
    localparam logic [8:0] W   = 9'h100;
    localparam logic [8:0] S1B = 9'h080;
    localparam logic [8:0] S1D = 9'h040;
    localparam logic [8:0] S2B = 9'h020;
    localparam logic [8:0] S2D = 9'h010;
    localparam logic [8:0] S3B = 9'h008;
    localparam logic [8:0] S3D = 9'h004;
    localparam logic [8:0] WN  = 9'h002;
    localparam logic [8:0] GO  = 9'h001;

    // Stimulus layout: {start_key, stage_clear, player_dead, done[8:0]}
    localparam logic [11:0] Z       = 12'h000;
    localparam logic [11:0] K       = 12'h800;
    localparam logic [11:0] C       = 12'h400;
    localparam logic [11:0] P       = 12'h200;
    localparam logic [11:0] DN_SAVE = 12'h100;
    localparam logic [11:0] DN_S1B  = 12'h080;
    localparam logic [11:0] DN_S1E  = 12'h040;
    localparam logic [11:0] DN_S2B  = 12'h020;
    localparam logic [11:0] DN_S2E  = 12'h010;
    localparam logic [11:0] DN_S3B  = 12'h008;
    localparam logic [11:0] DN_S3E  = 12'h004;
    localparam logic [11:0] DN_WIN  = 12'h002;
    localparam logic [11:0] DN_LOSE = 12'h001;

    typedef struct {
        logic [11:0] stim;
        logic [12:0] exp;
        int          reps;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start_key, stage_clear, player_dead;
    logic [8:0] done;
    logic       wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done;
    logic       stage_3_begin, stage_3_done, win, game_over, play_enable, display_rst;
    logic [1:0] stage_num;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    game_flow_controller #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .resetn(resetn), .start_key(start_key),
        .stage_clear(stage_clear), .player_dead(player_dead),
        .SAVE_GPA_done(done[8]), .stage_1_begin_done(done[7]),
        .stage_1_end_display_done(done[6]), .stage_2_begin_done(done[5]),
        .stage_2_end_display_done(done[4]), .stage_3_begin_done(done[3]),
        .stage_3_end_display_done(done[2]), .WIN_done(done[1]), .LOSE_done(done[0]),
        .wait_start(wait_start), .stage_1_begin(stage_1_begin), .stage_1_done(stage_1_done),
        .stage_2_begin(stage_2_begin), .stage_2_done(stage_2_done),
        .stage_3_begin(stage_3_begin), .stage_3_done(stage_3_done),
        .win(win), .game_over(game_over), .play_enable(play_enable),
        .stage_num(stage_num), .display_rst(display_rst)
    );

    always #5 clk = ~clk;

    wire [12:0] dut_out = {wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done,
                           stage_3_begin, stage_3_done, win, game_over,
                           play_enable, stage_num, display_rst};

    function automatic logic [12:0] o(logic [8:0] f, logic p, logic [1:0] s, logic d);
        return {f, p, s, d};
    endfunction

    function automatic void add(logic [11:0] st, logic [12:0] ex, int n);
        vec_t v;
        v.stim = st;
        v.exp  = ex;
        v.reps = n;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic [11:0] st);
        {start_key, stage_clear, player_dead, done} = st;
    endtask

    task automatic check(string name, logic [12:0] want);
        n_checks++;
        if (dut_out !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, dut_out, want);
        end
        n_checks++;
        if ($countones(dut_out[12:4]) > 1) begin
            n_fail++;
            $display("FAIL %s_onehot: got flags %b expected at most one high", name, dut_out[12:4]);
        end
    endtask

    task automatic run_vecs(string name);
        logic [12:0] want;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].stim);
                exp_q.push_back(vecs[i].exp);
                @(posedge clk);
                #1;
                want = exp_q.pop_front();
                check($sformatf("%s[%0d.%0d]", name, i, r), want);
            end
        end
        vecs.delete();
        drive(Z);
    endtask

    initial begin
        resetn = 1'b0;
        drive(Z);
        #2 resetn = 1'b1;
        #1 check("reset_async", o(W, 1'b0, 2'd0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_held", o(W, 1'b0, 2'd0, 1'b0));
        resetn = 1'b0;

        // Full win path; stale done inputs and start_key in hold/play must be ignored
        add(Z,       o(W,   1'b0, 2'd0, 1'b0), 2);
        add(DN_SAVE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 2);
        add(K,       o(S1B, 1'b0, 2'd1, 1'b0), 1);
        add(DN_WIN | DN_LOSE | DN_SAVE, o(S1B, 1'b0, 2'd1, 1'b0), 2);
        add(DN_S1B,  o(N,   1'b0, 2'd1, 1'b0), 1);
        add(K,       o(N,   1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd1, 1'b0), 2);
        add(Z,       o(N,   1'b1, 2'd1, 1'b0), 3);
        add(C,       o(S1D, 1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(S1D, 1'b0, 2'd1, 1'b0), 2);
        add(DN_S1E,  o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 3);
        add(Z,       o(S2B, 1'b0, 2'd2, 1'b0), 3);
        add(DN_S2B,  o(N,   1'b0, 2'd2, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd2, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd2, 1'b0), 1);
        add(K,       o(N,   1'b1, 2'd2, 1'b0), 2);
        add(C,       o(S2D, 1'b0, 2'd2, 1'b0), 1);
        add(Z,       o(S2D, 1'b0, 2'd2, 1'b0), 2);
        add(DN_S2E,  o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 3);
        add(Z,       o(S3B, 1'b0, 2'd3, 1'b0), 3);
        add(DN_S3B,  o(N,   1'b0, 2'd3, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd3, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd3, 1'b0), 1);
        add(C,       o(S3D, 1'b0, 2'd3, 1'b0), 1);
        add(Z,       o(S3D, 1'b0, 2'd3, 1'b0), 2);
        add(DN_S3E,  o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 3);
        add(Z,       o(WN,  1'b0, 2'd0, 1'b0), 3);
        add(DN_WIN,  o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 2);
        add(K | DN_SAVE, o(N, 1'b0, 2'd0, 1'b1), 1);
        add(DN_SAVE, o(W,   1'b0, 2'd0, 1'b0), 1);
        add(DN_SAVE, o(N,   1'b0, 2'd0, 1'b0), 1);
        run_vecs("win_path");

        // Death in stage 2, then restart through LOSE_IDLE
        add(K,       o(S1B, 1'b0, 2'd1, 1'b0), 1);
        add(DN_S1B,  o(N,   1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd1, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd1, 1'b0), 1);
        add(C,       o(S1D, 1'b0, 2'd1, 1'b0), 1);
        add(DN_S1E,  o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 3);
        add(Z,       o(S2B, 1'b0, 2'd2, 1'b0), 1);
        add(DN_S2B,  o(N,   1'b0, 2'd2, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd2, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd2, 1'b0), 2);
        add(P,       o(GO,  1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(GO,  1'b0, 2'd0, 1'b0), 1);
        add(DN_LOSE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd0, 1'b0), 1);
        add(K,       o(N,   1'b0, 2'd0, 1'b1), 1);
        add(Z,       o(W,   1'b0, 2'd0, 1'b0), 2);
        run_vecs("death_s2");

        // Simultaneous clear and death in S1_PLAY: death wins
        add(DN_SAVE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(K,       o(S1B, 1'b0, 2'd1, 1'b0), 1);
        add(DN_S1B,  o(N,   1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd1, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd1, 1'b0), 1);
        add(C | P,   o(GO,  1'b0, 2'd0, 1'b0), 1);
        add(C,       o(GO,  1'b0, 2'd0, 1'b0), 2);
        add(DN_LOSE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(K,       o(N,   1'b0, 2'd0, 1'b1), 1);
        add(Z,       o(W,   1'b0, 2'd0, 1'b0), 1);
        run_vecs("clear_and_dead");

        // Async reset in the middle of a hold (counter at 2)
        add(DN_SAVE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(K,       o(S1B, 1'b0, 2'd1, 1'b0), 1);
        add(DN_S1B,  o(N,   1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd1, 1'b0), 1);
        run_vecs("pre_rst");
        resetn = 1'b1;
        #2 check("rst_mid_hold", o(W, 1'b0, 2'd0, 1'b0));
        @(posedge clk);
        #1 resetn = 1'b0;

        // Fresh run after reset shows a full 4-cycle hold
        add(Z,       o(W,   1'b0, 2'd0, 1'b0), 1);
        add(DN_SAVE, o(N,   1'b0, 2'd0, 1'b0), 1);
        add(K,       o(S1B, 1'b0, 2'd1, 1'b0), 1);
        add(DN_S1B,  o(N,   1'b0, 2'd1, 1'b0), 1);
        add(Z,       o(N,   1'b0, 2'd1, 1'b0), 3);
        add(Z,       o(N,   1'b1, 2'd1, 1'b0), 2);
        run_vecs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
